mips: RTL and testbench
=======================

MIPS -- requirements
Module: mips

Interface
REQ-001 The parameter IMEM_WORDS SHALL default to 256 and set the instruction-memory depth in 32-bit words.
REQ-002 The parameter DMEM_WORDS SHALL default to 256 and set the data-memory depth in 32-bit words.
REQ-003 clk SHALL be an input, 1 bit wide, serving as the single clock; all state updates occur on its rising edge.
REQ-004 reset SHALL be an input, 1 bit wide, synchronous and active-high.
REQ-005 The block SHALL have no other ports; observation is hierarchical only.
REQ-006 The design SHALL expose a 32-bit program-counter register named pc.
REQ-007 The design SHALL contain an instruction-memory instance named InstructionMemory holding array imem[0:IMEM_WORDS-1] of 32 bits, loadable by $readmemh from the bench.
REQ-008 The design SHALL contain a data-memory instance named DataMemory holding array dmem[0:DMEM_WORDS-1] of 32 bits.

Function
REQ-009 The processor SHALL be single-cycle: each instruction fetches, decodes, executes, accesses memory and writes back within one clk period.
REQ-010 Instruction fetch SHALL be combinational, returning imem[pc[log2(IMEM_WORDS)+1:2]]; pc[1:0] is ignored.
REQ-011 The register file SHALL have 32 x 32-bit registers, two combinational read ports and one write port written on the rising edge.
REQ-012 Register $0 SHALL always read 0, and writes to it are discarded.
REQ-013 The R-type instructions add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra and jr SHALL be supported, using funct as is standard for MIPS-I.
REQ-014 The I-type instructions addi, addiu, andi, ori, xori, slti, sltiu, lui, lw, sw, beq and bne SHALL be supported.
REQ-015 The J-type instructions j and jal SHALL be supported; jal writes pc+4 to $31.
REQ-016 Arithmetic SHALL be 32-bit two's complement with wrap-around; no overflow exceptions are raised.
REQ-017 slt/slti SHALL compare as signed and sltu/sltiu as unsigned.
REQ-018 andi/ori/xori SHALL zero-extend the immediate; all other I-type instructions sign-extend it; lui places imm in bits [31:16].
REQ-019 The next PC SHALL be one of the following: pc+4 by default; pc+4+(signext(imm)<<2) for a taken beq/bne; {pc+4[31:28], target, 2'b00} for j/jal; rs for jr.
REQ-020 lw/sw addresses SHALL be rs+signext(imm) and word-aligned, indexing dmem[addr[log2(DMEM_WORDS)+1:2]]; low 2 bits are ignored.
REQ-021 lw SHALL read combinationally, and sw SHALL write dmem on the rising edge.
REQ-022 Unsupported opcodes SHALL execute as nop (no register/memory write, pc+4).
REQ-023 Addresses beyond memory depth SHALL wrap modulo the depth.

Reset
REQ-024 While reset is high at a rising edge, pc SHALL become 0x00000000, and no register or memory write occurs.
REQ-025 The register file SHALL clear to 0 on reset; dmem SHALL be zeroed at simulation start and is not cleared by reset.
REQ-026 imem SHALL never be modified by the design.
REQ-027 If reset is asserted mid-program, the in-flight instruction's write SHALL be suppressed, and execution restarts from 0 on the first edge with reset low.

Verification
REQ-028 Holding reset for 3 cycles then releasing it SHALL make pc 0x0 until release, then 0x4 after the next edge.
REQ-029 Executing addi $t0,$0,5; addi $t1,$0,-3; add $t2,$t0,$t1 SHALL leave $t2=2, and slt $t3,$t1,$t0 SHALL set $t3=1.
REQ-030 Executing addi $t0,$0,0x1234; sw $t0,60($0); lw $t1,60($0) SHALL give dmem[15]=0x00001234 and $t1=0x00001234.
REQ-031 A beq taken with offset -2 SHALL return pc to the prior instruction; when not taken, pc SHALL advance by 4; j to 0x54 SHALL set pc=0x54.
REQ-032 A power program (base 2, exponent 10, result via repeated-add multiply loop stored with sw at 60($0), ending with pc reaching 0x54) SHALL show dmem[15]=0x00000400 when pc==0x54.
REQ-033 Writing $0 with addi $0,$0,7 SHALL leave $0 reading 0.

Source files
------------

// File: rtl/mips.sv
// Single-cycle MIPS-I subset core with internal instruction and data memories.
// Fetch, decode, execute, memory access and write-back all complete in one clk period.

module mips_imem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] imem [0:WORDS-1];

  // Write port is tied off in the core; program contents are preloaded externally.
  always_ff @(posedge clk) begin
    if (we_i) imem[waddr_i] <= wdata_i;
  end

  assign rdata_o = imem[raddr_i];
endmodule

module mips_dmem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] dmem [0:WORDS-1];

  // Store word on the rising edge; loads read combinationally below.
  always_ff @(posedge clk) begin
    if (we_i) dmem[addr_i] <= wdata_i;
  end

  assign rdata_o = dmem[addr_i];
endmodule

module mips #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic clk,
  input logic reset
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] pc;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [31:0] rf_q [0:31];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] rs_val, rt_val, imm_se, imm_ze;
  logic [31:0] br_target, jump_target, dmem_rdata;
  logic [DAW-1:0] dmem_idx;

  logic        reg_we, mem_we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  mips_imem #(.WORDS(IMEM_WORDS), .AW(IAW)) InstructionMemory (
    .clk     (clk),
    .we_i    (1'b0),
    .waddr_i ({IAW{1'b0}}),
    .wdata_i (32'd0),
    .raddr_i (IAW'(pc >> 2)),
    .rdata_o (instr)
  );

  mips_dmem #(.WORDS(DMEM_WORDS), .AW(DAW)) DataMemory (
    .clk     (clk),
    .we_i    (mem_we & ~reset),
    .addr_i  (dmem_idx),
    .wdata_i (rt_val),
    .rdata_o (dmem_rdata)
  );

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign target = instr[25:0];

  assign rs_val      = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val      = (rt == 5'd0) ? 32'd0 : rf_q[rt];
  assign imm_se      = {{16{imm[15]}}, imm};
  assign imm_ze      = {16'h0000, imm};
  assign pc_plus4    = pc + 32'd4;
  assign br_target   = pc_plus4 + {imm_se[29:0], 2'b00};
  assign jump_target = {pc_plus4[31:28], target, 2'b00};
  // Word index wraps modulo the data-memory depth; byte offset bits are dropped.
  assign dmem_idx    = DAW'((rs_val + imm_se) >> 2);

  // Decode and execute: selects register write-back, store enable and next PC.
  always_comb begin
    reg_we  = 1'b0;
    wr_addr = rd;
    wr_data = 32'd0;
    mem_we  = 1'b0;
    pc_d    = pc_plus4;
    case (opcode)
      6'h00: begin
        reg_we = 1'b1;
        case (funct)
          6'h20, 6'h21: wr_data = rs_val + rt_val;
          6'h22, 6'h23: wr_data = rs_val - rt_val;
          6'h24:        wr_data = rs_val & rt_val;
          6'h25:        wr_data = rs_val | rt_val;
          6'h26:        wr_data = rs_val ^ rt_val;
          6'h27:        wr_data = ~(rs_val | rt_val);
          6'h2a:        wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h2b:        wr_data = {31'd0, rs_val < rt_val};
          6'h00:        wr_data = rt_val << shamt;
          6'h02:        wr_data = rt_val >> shamt;
          6'h03:        wr_data = $signed(rt_val) >>> shamt;
          6'h08: begin
            reg_we = 1'b0;
            pc_d   = rs_val;
          end
          default:      reg_we = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin reg_we = 1'b1; wr_addr = rt; wr_data = rs_val + imm_se; end
      6'h0c:        begin reg_we = 1'b1; wr_addr = rt; wr_data = rs_val & imm_ze; end
      6'h0d:        begin reg_we = 1'b1; wr_addr = rt; wr_data = rs_val | imm_ze; end
      6'h0e:        begin reg_we = 1'b1; wr_addr = rt; wr_data = rs_val ^ imm_ze; end
      6'h0a: begin
        reg_we = 1'b1; wr_addr = rt; wr_data = {31'd0, $signed(rs_val) < $signed(imm_se)};
      end
      6'h0b:        begin reg_we = 1'b1; wr_addr = rt; wr_data = {31'd0, rs_val < imm_se}; end
      6'h0f:        begin reg_we = 1'b1; wr_addr = rt; wr_data = {imm, 16'h0000}; end
      6'h23:        begin reg_we = 1'b1; wr_addr = rt; wr_data = dmem_rdata; end
      6'h2b:        mem_we = 1'b1;
      6'h04:        if (rs_val == rt_val) pc_d = br_target;
      6'h05:        if (rs_val != rt_val) pc_d = br_target;
      6'h02:        pc_d = jump_target;
      6'h03: begin
        pc_d    = jump_target;
        reg_we  = 1'b1;
        wr_addr = 5'd31;
        wr_data = pc_plus4;
      end
      default: ;
    endcase
  end

  // Program counter: restart from address 0 while reset is held.
  always_ff @(posedge clk) begin
    if (reset) pc <= 32'd0;
    else       pc <= pc_d;
  end

  // Register file: cleared on reset, $0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (reg_we && (wr_addr != 5'd0)) begin
      rf_q[wr_addr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_mips.sv
// Self-checking bench for the single-cycle mips core: directed programs plus a
// randomized straight-line program checked against an instruction-level model.

module tb_mips;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mips #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (.clk(clk), .reset(reset));

  localparam int K_ADD = 0, K_ADDU = 1, K_SUB = 2, K_SUBU = 3, K_AND = 4, K_OR = 5,
                 K_XOR = 6, K_NOR = 7, K_SLT = 8, K_SLTU = 9, K_SLL = 10, K_SRL = 11,
                 K_SRA = 12, K_ADDI = 13, K_ADDIU = 14, K_ANDI = 15, K_ORI = 16,
                 K_XORI = 17, K_SLTI = 18, K_SLTIU = 19, K_LUI = 20, K_LW = 21,
                 K_SW = 22, K_BADOP = 23, K_BADFN = 24, K_NKINDS = 25;

  typedef struct {
    int          kind;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
  } ins_t;

  logic [31:0] m_rf  [0:31];
  logic [31:0] m_mem [0:255];
  logic [31:0] m_pc;
  ins_t        prog  [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  function automatic logic [31:0] encode(input ins_t p);
    case (p.kind)
      K_ADD:   return enc_r(6'h20, p.rs, p.rt, p.rd, 5'd0);
      K_ADDU:  return enc_r(6'h21, p.rs, p.rt, p.rd, 5'd0);
      K_SUB:   return enc_r(6'h22, p.rs, p.rt, p.rd, 5'd0);
      K_SUBU:  return enc_r(6'h23, p.rs, p.rt, p.rd, 5'd0);
      K_AND:   return enc_r(6'h24, p.rs, p.rt, p.rd, 5'd0);
      K_OR:    return enc_r(6'h25, p.rs, p.rt, p.rd, 5'd0);
      K_XOR:   return enc_r(6'h26, p.rs, p.rt, p.rd, 5'd0);
      K_NOR:   return enc_r(6'h27, p.rs, p.rt, p.rd, 5'd0);
      K_SLT:   return enc_r(6'h2a, p.rs, p.rt, p.rd, 5'd0);
      K_SLTU:  return enc_r(6'h2b, p.rs, p.rt, p.rd, 5'd0);
      K_SLL:   return enc_r(6'h00, 5'd0, p.rt, p.rd, p.sh);
      K_SRL:   return enc_r(6'h02, 5'd0, p.rt, p.rd, p.sh);
      K_SRA:   return enc_r(6'h03, 5'd0, p.rt, p.rd, p.sh);
      K_ADDI:  return enc_i(6'h08, p.rs, p.rt, p.imm);
      K_ADDIU: return enc_i(6'h09, p.rs, p.rt, p.imm);
      K_ANDI:  return enc_i(6'h0c, p.rs, p.rt, p.imm);
      K_ORI:   return enc_i(6'h0d, p.rs, p.rt, p.imm);
      K_XORI:  return enc_i(6'h0e, p.rs, p.rt, p.imm);
      K_SLTI:  return enc_i(6'h0a, p.rs, p.rt, p.imm);
      K_SLTIU: return enc_i(6'h0b, p.rs, p.rt, p.imm);
      K_LUI:   return enc_i(6'h0f, 5'd0, p.rt, p.imm);
      K_LW:    return enc_i(6'h23, p.rs, p.rt, p.imm);
      K_SW:    return enc_i(6'h2b, p.rs, p.rt, p.imm);
      K_BADOP: return enc_i(6'h3f, p.rs, p.rt, p.imm);
      default: return enc_r(6'h3f, p.rs, p.rt, p.rd, 5'd0);
    endcase
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.InstructionMemory.imem[i] = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_pc", dut.pc, 32'd0);
    end
    check("reset_rf_t0", dut.rf_q[8], 32'd0);
    check("reset_rf_t1", dut.rf_q[9], 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, se, res;
    int          dst, idx, ismem, kind;
    bit          done;

    for (int i = 0; i < 256; i++) dut.DataMemory.dmem[i] = 32'd0;
    clear_imem();

    // Reset hold and release on a nop-filled program
    do_reset();
    tick();
    check("release_pc", dut.pc, 32'h4);
    $display("[TB] reset release pc=%h", dut.pc);

    // Arithmetic, $0 write, store/load, branches, jumps, jal/jr
    clear_imem();
    dut.InstructionMemory.imem[0]  = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
    dut.InstructionMemory.imem[1]  = enc_i(6'h08, 5'd0, 5'd9, 16'hFFFD);
    dut.InstructionMemory.imem[2]  = enc_r(6'h20, 5'd8, 5'd9, 5'd10, 5'd0);
    dut.InstructionMemory.imem[3]  = enc_r(6'h2a, 5'd9, 5'd8, 5'd11, 5'd0);
    dut.InstructionMemory.imem[4]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    dut.InstructionMemory.imem[5]  = enc_i(6'h08, 5'd0, 5'd8, 16'h1234);
    dut.InstructionMemory.imem[6]  = enc_i(6'h2b, 5'd0, 5'd8, 16'd60);
    dut.InstructionMemory.imem[7]  = enc_i(6'h23, 5'd0, 5'd9, 16'd60);
    dut.InstructionMemory.imem[8]  = enc_i(6'h04, 5'd9, 5'd10, 16'hFFFE);
    dut.InstructionMemory.imem[9]  = enc_i(6'h08, 5'd12, 5'd12, 16'd1);
    dut.InstructionMemory.imem[10] = enc_i(6'h04, 5'd12, 5'd11, 16'hFFFE);
    dut.InstructionMemory.imem[11] = enc_j(6'h02, 26'h15);
    dut.InstructionMemory.imem[21] = enc_j(6'h03, 26'h18);
    dut.InstructionMemory.imem[22] = enc_j(6'h02, 26'h16);
    dut.InstructionMemory.imem[24] = enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
    do_reset();
    tick(); check("addi_pos_pc", dut.pc, 32'h04); check("addi_pos", dut.rf_q[8], 32'd5);
    tick(); check("addi_neg", dut.rf_q[9], 32'hFFFFFFFD);
    tick(); check("add_wrap", dut.rf_q[10], 32'd2);
    tick(); check("slt_signed", dut.rf_q[11], 32'd1);
    tick(); check("r0_stays_zero", dut.rf_q[0], 32'd0); check("r0_pc", dut.pc, 32'h14);
    tick(); check("addi_1234", dut.rf_q[8], 32'h1234);
    tick(); check("sw_dmem15", dut.DataMemory.dmem[15], 32'h1234);
    tick(); check("lw_t1", dut.rf_q[9], 32'h1234); check("lw_pc", dut.pc, 32'h20);
    tick(); check("beq_not_taken", dut.pc, 32'h24);
    tick(); check("loop_addi", dut.rf_q[12], 32'd1);
    tick(); check("beq_taken_back", dut.pc, 32'h24);
    tick(); check("loop_addi2", dut.rf_q[12], 32'd2);
    tick(); check("beq_fallthrough", dut.pc, 32'h2c);
    tick(); check("j_0x54", dut.pc, 32'h54);
    tick(); check("jal_pc", dut.pc, 32'h60); check("jal_ra", dut.rf_q[31], 32'h58);
    tick(); check("jr_pc", dut.pc, 32'h58);
    tick(); check("j_self", dut.pc, 32'h58);
    $display("[TB] directed program done pc=%h", dut.pc);

    // Power program: 2^10 by repeated-add multiply, stored at 60($0)
    clear_imem();
    dut.InstructionMemory.imem[0]  = enc_i(6'h08, 5'd0, 5'd16, 16'd2);
    dut.InstructionMemory.imem[1]  = enc_i(6'h08, 5'd0, 5'd17, 16'd10);
    dut.InstructionMemory.imem[2]  = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
    dut.InstructionMemory.imem[3]  = enc_i(6'h04, 5'd17, 5'd0, 16'd8);
    dut.InstructionMemory.imem[4]  = enc_i(6'h08, 5'd0, 5'd8, 16'd0);
    dut.InstructionMemory.imem[5]  = enc_i(6'h08, 5'd0, 5'd9, 16'd0);
    dut.InstructionMemory.imem[6]  = enc_r(6'h20, 5'd8, 5'd2, 5'd8, 5'd0);
    dut.InstructionMemory.imem[7]  = enc_i(6'h08, 5'd9, 5'd9, 16'd1);
    dut.InstructionMemory.imem[8]  = enc_i(6'h05, 5'd9, 5'd16, 16'hFFFD);
    dut.InstructionMemory.imem[9]  = enc_r(6'h20, 5'd8, 5'd0, 5'd2, 5'd0);
    dut.InstructionMemory.imem[10] = enc_i(6'h08, 5'd17, 5'd17, 16'hFFFF);
    dut.InstructionMemory.imem[11] = enc_j(6'h02, 26'h3);
    dut.InstructionMemory.imem[12] = enc_i(6'h2b, 5'd0, 5'd2, 16'd60);
    dut.InstructionMemory.imem[13] = enc_j(6'h02, 26'h15);
    dut.InstructionMemory.imem[21] = enc_j(6'h02, 26'h15);
    do_reset();
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      tick();
      if (dut.pc == 32'h54) done = 1'b1;
    end
    check("power_reach_0x54", dut.pc, 32'h54);
    check("power_dmem15", dut.DataMemory.dmem[15], 32'h400);
    check("power_v0", dut.rf_q[2], 32'h400);
    $display("[TB] power program pc=%h dmem[15]=%h", dut.pc, dut.DataMemory.dmem[15]);

    // Randomized straight-line program against the instruction-level model
    for (int i = 0; i < 256; i++) begin
      dut.DataMemory.dmem[i] = 32'd0;
      m_mem[i] = 32'd0;
    end
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    clear_imem();
    for (int k = 0; k < 64; k++) begin
      prog[k].rs  = 5'($urandom_range(0, 9));
      prog[k].rt  = 5'($urandom_range(0, 9));
      prog[k].rd  = 5'($urandom % 32);
      prog[k].sh  = 5'($urandom % 32);
      prog[k].imm = 16'($urandom);
      if (k < 16) begin
        prog[k].kind = (k % 2 == 0) ? K_LUI : K_ORI;
        prog[k].rt   = 5'(1 + k / 2);
        prog[k].rs   = prog[k].rt;
      end else begin
        prog[k].kind = int'($urandom % K_NKINDS);
      end
      dut.InstructionMemory.imem[k] = encode(prog[k]);
    end
    dut.InstructionMemory.imem[64] = enc_j(6'h02, 26'd64);
    do_reset();
    m_pc = 32'd0;
    for (int k = 0; k < 64; k++) begin
      kind  = prog[k].kind;
      a     = m_rf[prog[k].rs];
      b     = m_rf[prog[k].rt];
      se    = {{16{prog[k].imm[15]}}, prog[k].imm};
      dst   = (kind <= K_SRA || kind == K_BADFN) ? int'(prog[k].rd) : int'(prog[k].rt);
      idx   = int'(((a + se) / 4) % 256);
      ismem = 0;
      res   = m_rf[dst];
      case (kind)
        K_ADD, K_ADDU: res = a + b;
        K_SUB, K_SUBU: res = a - b;
        K_AND:   res = a & b;
        K_OR:    res = a | b;
        K_XOR:   res = a ^ b;
        K_NOR:   res = ~(a | b);
        K_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        K_SLTU:  res = (a < b) ? 32'd1 : 32'd0;
        K_SLL:   res = b << prog[k].sh;
        K_SRL:   res = b >> prog[k].sh;
        K_SRA:   res = $signed(b) >>> prog[k].sh;
        K_ADDI, K_ADDIU: res = a + se;
        K_ANDI:  res = a & {16'h0, prog[k].imm};
        K_ORI:   res = a | {16'h0, prog[k].imm};
        K_XORI:  res = a ^ {16'h0, prog[k].imm};
        K_SLTI:  res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
        K_SLTIU: res = (a < se) ? 32'd1 : 32'd0;
        K_LUI:   res = {prog[k].imm, 16'h0};
        K_LW:    res = m_mem[idx];
        K_SW:    begin m_mem[idx] = b; ismem = 1; end
        default: ;
      endcase
      if (!ismem && dst != 0) m_rf[dst] = res;
      m_pc = m_pc + 32'd4;
      tick();
      $display("[TB] rnd %0d kind=%0d instr=%h pc=%h", k, kind, encode(prog[k]), dut.pc);
      check($sformatf("rnd_pc_%0d", k), dut.pc, m_pc);
      if (ismem) check($sformatf("rnd_sw_%0d", k), dut.DataMemory.dmem[idx], m_mem[idx]);
      else       check($sformatf("rnd_rf_%0d", k), dut.rf_q[dst], m_rf[dst]);
    end
    for (int r = 0; r < 32; r++) check($sformatf("rnd_final_r%0d", r), dut.rf_q[r], m_rf[r]);

    // Reset asserted while a store is in flight suppresses the store
    clear_imem();
    dut.InstructionMemory.imem[0] = enc_i(6'h08, 5'd0, 5'd8, 16'h0055);
    dut.InstructionMemory.imem[1] = enc_i(6'h2b, 5'd0, 5'd8, 16'd8);
    dut.InstructionMemory.imem[2] = enc_j(6'h02, 26'd2);
    do_reset();
    tick(); check("mid_pre_pc", dut.pc, 32'h4); check("mid_pre_t0", dut.rf_q[8], 32'h55);
    reset = 1'b1;
    tick();
    check("mid_reset_pc", dut.pc, 32'h0);
    check("mid_reset_sw_blocked", dut.DataMemory.dmem[2], m_mem[2]);
    check("mid_reset_rf", dut.rf_q[8], 32'h0);
    reset = 1'b0;
    tick(); check("mid_restart_pc", dut.pc, 32'h4); check("mid_restart_t0", dut.rf_q[8], 32'h55);
    tick(); check("mid_sw_pc", dut.pc, 32'h8); check("mid_sw_dmem2", dut.DataMemory.dmem[2], 32'h55);
    $display("[TB] mid-program reset sequence pc=%h", dut.pc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
